shift_reg_seq_ctrl: RTL
=======================

// Module: shift_reg_seq_ctrl
// PURPOSE
// - Upstream sequencer for the 4-bit universal shift register.
// - Accepts a 4-bit word on a valid/ready handshake, loads it into the register, then issues 4 paced shift commands.
// - Presents each bit leaving the register as a serial strobe and pulses done at the end.
// - Drives the register's mode select M, parallel data D and serial-in SI; observes its Q.
// PARAMETERS
// - DIV  4  clocks per shift step, >=1; shift command issued on the last clock of each step
// PORTS
// - clk        in   1  system clock, all state on rising edge
// - reset      in   1  asynchronous, active-low reset
// - in_valid   in   1  word offered
// - in_ready   out  1  controller idle and able to accept
// - in_data    in   4  word to serialise, captured on accept
// - in_rotate  in   1  captured on accept; 0=shift right (M=11), 1=rotate left (M=10)
// - fill_bit   in   1  captured on accept; driven on SI for every shift-right step
// - q          in   4  shift register Q
// - M          out  2  register mode: 00 hold, 01 load, 10 rotate left, 11 shift right
// - D          out  4  register parallel data (captured word)
// - SI         out  1  register serial input
// - ser_valid  out  1  one-clock strobe: ser_out valid this cycle
// - ser_out    out  1  bit leaving: q[0] (shift right) or q[3] (rotate)
// - done       out  1  one-clock pulse after 4th shift
// BEHAVIOUR
// - Reset asserted (any time, incl. mid-word): state=IDLE; all counters=0.
//   Outputs in_ready=0, M=00, D=0000, SI=0, ser_valid=0, ser_out=0, done=0.
// - in_ready is registered; first clock edge after reset release sets it to 1.
// - States: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
// - IDLE: in_ready=1, M=00.
//   - in_valid&&in_ready at an edge: capture in_data->D, in_rotate, fill_bit; go LOAD; in_ready=0 next cycle.
// - LOAD: exactly 1 cycle with M=01 (register loads D at end of cycle); clear div_cnt and bit_cnt; go SHIFT.
// - SHIFT: div_cnt counts 0..DIV-1.
//   - div_cnt<DIV-1: M=00, ser_valid=0.
//   - div_cnt==DIV-1: M=11 or 10 per captured mode; ser_valid=1; ser_out taken combinationally from current q (pre-shift); bit_cnt++.
//   - After 4th strobe (bit_cnt was 3): go DONE.
// - DONE: 1 cycle, done=1, M=00; then IDLE with in_ready=1.
//   - No back-to-back accept in the DONE cycle.
// - SI = captured fill_bit while busy, 0 in IDLE; ignored by register in rotate mode.
// - Latency: accept edge -> done cycle = 1 + 4*DIV + 1 clocks.
//   - Words per 4*DIV+3 clocks max, incl. IDLE accept cycle.
// - in_valid/in_data ignored while busy; source must hold them until accepted.
// - DIV=1: every SHIFT cycle is a shift cycle, div_cnt held at 0.
// - q is not checked; controller trusts register response.
// TESTING
// - Reset release, in_valid=0: M=00, in_ready 0 then 1 after one edge; outputs stay 0.
// - DIV=1, in_data=1011, rotate=0, fill=0: LOAD 1 cycle; 4 strobes ser_out=1,1,0,1.
//   - q ends 0000; done 6 cycles after accept.
// - DIV=4, in_data=1000, rotate=1: ser_valid every 4th clock; ser_out=1,0,0,0; q returns to 1000; done at 18 clocks.
// - fill=1, in_data=0000, shift right: SI=1 throughout; q ends 1111; ser_out all 0.
// - in_valid held high with new data during SHIFT: no capture, D unchanged; next word accepted only after done, in IDLE.
// - reset pulsed low mid-SHIFT after 2 strobes: M=00, ser_valid=0 immediately (async); restart accepts fresh word normally.

Source files
------------

// File: rtl/shift_reg_seq_ctrl.sv
// Sequencer for a 4-bit universal shift register: load a word, then
// issue four paced shift/rotate commands and strobe out each bit.
module shift_reg_seq_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_rotate,
  input  logic       fill_bit,
  input  logic [3:0] q,
  output logic [1:0] M,
  output logic [3:0] D,
  output logic       SI,
  output logic       ser_valid,
  output logic       ser_out,
  output logic       done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
  localparam bit DIV1 = (DIV == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [1:0]    bit_cnt;
  logic          rot;

  logic [1:0]    smode;
  logic [DW-1:0] div_nxt;
  logic          nxt_hit;

  assign smode   = rot ? 2'b10 : 2'b11;
  assign div_nxt = div_cnt + DW'(1);
  assign nxt_hit = (div_nxt == DLAST);

  // bit leaving the register before this cycle's shift lands
  assign ser_out = ser_valid & (rot ? q[3] : q[0]);

  // M and ser_valid are registered, so each branch looks one cycle ahead
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      rot       <= 1'b0;
      in_ready  <= 1'b0;
      M         <= 2'b00;
      D         <= 4'b0000;
      SI        <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      M         <= 2'b00;
      ser_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          SI       <= 1'b0;
          if (in_valid && in_ready) begin
            D        <= in_data;
            rot      <= in_rotate;
            SI       <= fill_bit;
            in_ready <= 1'b0;
            M        <= 2'b01;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= S_SHIFT;
          if (DIV1) begin
            M         <= smode;
            ser_valid <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (div_cnt == DLAST) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 2'd1;
            if (bit_cnt == 2'd3) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (DIV1) begin
              M         <= smode;
              ser_valid <= 1'b1;
            end
          end else begin
            div_cnt <= div_nxt;
            if (nxt_hit) begin
              M         <= smode;
              ser_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          SI       <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
